// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: captures a cipher key on start, then streams round keys 0..10
// under a valid/ready handshake, computing each key on the fly from the previous one.

module aes_sbox (
   input  logic [7:0] byteIn,
   output logic [7:0] byteOut
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign byteOut = SBOX[byteIn];
endmodule

module aes_key_schedule (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         key_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         key_valid,
   output logic         busy,
   output logic         done
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   stateT       state, nextState;
   logic [7:0]  rcon, nextRcon;
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rotWord, subWord, temp;
   logic [31:0] n0, n1, n2, n3;
   logic        accept, lastKey;

   // Next-key datapath: one S-box row on the rotated last word, then the XOR chain.
   assign {w0, w1, w2, w3} = round_key;
   assign rotWord = {w3[23:0], w3[31:24]};

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : gSbox
         aes_sbox uSbox (
            .byteIn (rotWord[8*i +: 8]),
            .byteOut(subWord[8*i +: 8])
         );
      end
   endgenerate

   assign temp = subWord ^ {rcon, 24'h0};
   assign n0   = w0 ^ temp;
   assign n1   = w1 ^ n0;
   assign n2   = w2 ^ n1;
   assign n3   = w3 ^ n2;

   assign nextRcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
   assign accept   = (state == RUN) && key_ready;
   assign lastKey  = (round_idx == LAST_ROUND);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (accept && lastKey) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      key_valid = (state == RUN);
      busy      = (state == RUN);
   end

   // Key registers hold on stall; the final accept only pulses done and leaves them frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_key <= '0;
         round_idx <= '0;
         rcon      <= 8'h01;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            round_key <= key_in;
            round_idx <= '0;
            rcon      <= 8'h01;
         end else if (accept) begin
            if (lastKey) begin
               done <= 1'b1;
            end else begin
               round_key <= {n0, n1, n2, n3};
               round_idx <= round_idx + 4'd1;
               rcon      <= nextRcon;
            end
         end
      end
   end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors, backpressure, start/reset
// corner cases and random keys against a GF(2^8)-derived key-expansion model.

module tb_aes_key_schedule;
   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         key_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         busy;
   logic         done;

   aes_key_schedule dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .key_ready(key_ready),
      .round_key(round_key),
      .round_idx(round_idx),
      .key_valid(key_valid),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      int           idx;
      logic [127:0] expKey;
   } vecT;

   localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int           nChecks = 0;
   int           nErrors = 0;
   logic [7:0]   refSbox [256];
   logic [127:0] refKeys [11];
   logic [127:0] got [11];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: S-box from GF(2^8) inversion plus affine map, FIPS-197 word expansion.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic buildSbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h01;
         if (a == 0) inv = 8'h00;
         else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
         refSbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expandRef(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {refSbox[t[31:24]], refSbox[t[23:16]], refSbox[t[15:8]], refSbox[t[7:0]]};
            t ^= {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Called just after an active edge; leaves the bench at E+1 where key 0 should be visible.
   task automatic issueStart(input logic [127:0] key);
      foreach (got[k]) got[k] = '0;
      start     = 1'b1;
      key_in    = key;
      key_ready = 1'b0;
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   // Consumes keys with random readiness; optionally pokes start mid-run and/or restarts in the done cycle.
   task automatic consume(input int readyPct, input int pokeIdx, input bit chainEn,
                          input logic [127:0] chainKey, output int doneCycle);
      logic [127:0] heldKey;
      logic [3:0]   heldIdx;
      bit           stalled, poked, ended;
      int           expIdx, dones;
      stalled = 1'b0; poked = 1'b0; ended = 1'b0;
      expIdx = 0; dones = 0; doneCycle = -1;
      heldKey = '0; heldIdx = '0;
      for (int cyc = 1; cyc <= 400 && !ended; cyc++) begin
         if (done) begin
            dones++;
            doneCycle = cyc;
            check("validLowAtDone", 128'(key_valid), 128'd0);
            check("busyLowAtDone", 128'(busy), 128'd0);
            key_ready = 1'b0;
            if (chainEn) begin
               start  = 1'b1;
               key_in = chainKey;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (chainEn) begin
               key_in = ~chainKey;
               check("chainValid", 128'(key_valid), 128'd1);
               check("chainIdx0", 128'(round_idx), 128'd0);
               check("chainKey0", round_key, chainKey);
            end else begin
               check("donePulseWidth", 128'(done), 128'd0);
            end
            ended = 1'b1;
         end else if (!key_valid) begin
            check("validHeld", 128'(key_valid), 128'd1);
            ended = 1'b1;
         end else begin
            if (stalled) begin
               check("stallKeyStable", round_key, heldKey);
               check("stallIdxStable", 128'(round_idx), 128'(heldIdx));
            end
            check("idxOrder", 128'(round_idx), 128'(expIdx));
            start = 1'b0;
            if (!poked && int'(round_idx) == pokeIdx) begin
               start  = 1'b1;
               key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
               poked  = 1'b1;
            end
            key_ready = (int'($urandom_range(0, 99)) < readyPct);
            if (key_ready) begin
               if (round_idx <= 4'd10) got[round_idx] = round_key;
               expIdx++;
            end
            stalled = !key_ready;
            heldKey = round_key;
            heldIdx = round_idx;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      check("exactlyOneDone", 128'(dones), 128'd1);
   endtask

   task automatic compareAll(input string tag);
      for (int r = 0; r < 11; r++) check($sformatf("%s_key%0d", tag, r), got[r], refKeys[r]);
   endtask

   vecT vecs [8];
   int  dc;

   initial begin
      vecs[0] = '{KEY_A1, 0,  KEY_A1};
      vecs[1] = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2] = '{KEY_A1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3] = '{KEY_A1, 9,  128'hac7766f319fadc2128d12941575c006e};
      vecs[4] = '{KEY_A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[5] = '{128'h0, 0,  128'h0};
      vecs[6] = '{128'h0, 1,  128'h62636363626363636263636362636363};
      vecs[7] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      rst_n = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("rstValid", 128'(key_valid), 128'd0);
      check("rstBusy", 128'(busy), 128'd0);
      check("rstDone", 128'(done), 128'd0);
      check("rstIdx", 128'(round_idx), 128'd0);
      check("rstKey", round_key, 128'd0);
      buildSbox();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer table with key_ready tied high; done must land in cycle E+12.
      foreach (vecs[v]) begin
         issueStart(vecs[v].key);
         consume(100, -1, 1'b0, '0, dc);
         check($sformatf("vec%0d_doneCycle", v), 128'(dc), 128'd12);
         check($sformatf("vec%0d_idx%0d", v, vecs[v].idx), got[vecs[v].idx], vecs[v].expKey);
      end

      // Backpressure on the A.1 key.
      expandRef(KEY_A1);
      issueStart(KEY_A1);
      consume(45, -1, 1'b0, '0, dc);
      compareAll("bp");

      // Start poked at idx 4 is ignored; start in the done cycle launches a new key.
      begin
         logic [127:0] nextKey;
         nextKey = {$urandom(), $urandom(), $urandom(), $urandom()};
         issueStart(KEY_A1);
         consume(70, 4, 1'b1, nextKey, dc);
         compareAll("poke");
         foreach (got[k]) got[k] = '0;
         expandRef(nextKey);
         consume(100, -1, 1'b0, '0, dc);
         compareAll("chain");
         check("chainDoneCycle", 128'(dc), 128'd12);
      end

      // Asynchronous reset at idx 6, then a clean sequence from rcon=01.
      issueStart(KEY_A1);
      key_ready = 1'b1;
      for (int k = 0; k < 20 && round_idx != 4'd6; k++) begin
         @(posedge clk); #1;
      end
      check("reachedIdx6", 128'(round_idx), 128'd6);
      #3 rst_n = 1'b0;
      #1;
      check("asyncRstValid", 128'(key_valid), 128'd0);
      check("asyncRstBusy", 128'(busy), 128'd0);
      check("asyncRstDone", 128'(done), 128'd0);
      check("asyncRstIdx", 128'(round_idx), 128'd0);
      key_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      begin
         logic [127:0] rk;
         rk = {$urandom(), $urandom(), $urandom(), $urandom()};
         expandRef(rk);
         issueStart(rk);
         consume(100, -1, 1'b0, '0, dc);
         compareAll("postRst");
      end

      // Random keys with random readiness against the model.
      for (int n = 0; n < 6; n++) begin
         logic [127:0] rk;
         rk = {$urandom(), $urandom(), $urandom(), $urandom()};
         expandRef(rk);
         issueStart(rk);
         consume(int'($urandom_range(20, 100)), -1, 1'b0, '0, dc);
         compareAll($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
